// File: rtl/insn_mem_decode_pkg.sv
// Shared constants for the unified instruction/data memory and its field decoder.
// Holds access sizes, MIPS opcode values, instruction-class encodings and field positions.
package insn_mem_decode_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h8002_0000;
  localparam int          DEPTH_BYTES_DEFAULT = 1048576;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;

  typedef enum logic [1:0] {
    ITYPE_R = 2'b00,
    ITYPE_J = 2'b01,
    ITYPE_I = 2'b10
  } itype_e;

  // Low bit position of each MIPS field within the instruction word
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  function automatic itype_e classify(input logic [5:0] op);
    if (op == OP_RTYPE)                return ITYPE_R;
    else if (op == OP_J || op == OP_JAL) return ITYPE_J;
    else                               return ITYPE_I;
  endfunction

endpackage

// File: rtl/insn_field_decode.sv
// Combinational split of a fetched MIPS word into its fields, immediate and jump target.
module insn_field_decode
  import insn_mem_decode_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  pc_hi,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm,
  output logic [31:0] target,
  output logic [1:0]  itype
);

  assign opcode = word[OPC_LSB   +: 6];
  assign rs     = word[RS_LSB    +: 5];
  assign rt     = word[RT_LSB    +: 5];
  assign rd     = word[RD_LSB    +: 5];
  assign shamt  = word[SHAMT_LSB +: 5];
  assign funct  = word[FUNCT_LSB +: 6];
  assign imm    = {{16{word[15]}}, word[15:0]};
  // Jump target keeps the current 256MB region of the PC
  assign target = {pc_hi, word[25:0], 2'b00};
  assign itype  = classify(word[OPC_LSB +: 6]);

endmodule

// File: rtl/insn_mem_decode.sv
// Big-endian byte-addressed memory with one-cycle registered read and a field decoder on the output.
// Optional access-error flag enabled by defining MEM_ERR_CHECK_EN.
module insn_mem_decode
  import insn_mem_decode_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  input  logic [1:0]  access_size,
  input  logic [31:0] pc_in,
  output logic [31:0] data_out,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  shamt_out,
  output logic [5:0]  funct_out,
  output logic [31:0] imm_out,
  output logic [31:0] target_out,
  output logic [1:0]  itype_out,
  output logic        err_out
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-3:0] widx;
  logic          is_word;
  logic          is_half;
  logic [3:0]    lane_we;
  logic [7:0]    wbyte [4];
  logic [7:0]    rd_b  [4];
  logic [31:0]   rd_val;
  logic [31:0]   data_q;
  logic [31:0]   pc_q;

  // Unsigned offset: addresses below the base wrap to huge values and fall out of range
  assign off      = address - BASE_ADDR;
  assign in_range = off < 32'(DEPTH_BYTES);
  assign widx     = off[AW-1:2];
  assign is_word  = access_size[1];
  assign is_half  = (access_size == SZ_HALF);

  // Lane 0 holds the most significant byte of each word (big-endian)
  always_comb begin
    wbyte[0] = is_word ? data_in[31:24] : (is_half ? data_in[15:8] : data_in[7:0]);
    wbyte[1] = is_word ? data_in[23:16] : data_in[7:0];
    wbyte[2] = (is_word || is_half) ? data_in[15:8] : data_in[7:0];
    wbyte[3] = data_in[7:0];
  end

  always_comb begin
    lane_we = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      if (is_word)      lane_we[l] = 1'b1;
      else if (is_half) lane_we[l] = (2'(l) >> 1) == {1'b0, off[1]};
      else              lane_we[l] = 2'(l) == off[1:0];
    end
    if (!write || !in_range) lane_we = 4'b0000;
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] bank [WORDS];
    always_ff @(posedge clk_in) begin
      if (lane_we[l]) bank[widx] <= wbyte[l];
    end
    assign rd_b[l] = bank[widx];
  end

  always_comb begin
    rd_val = 32'd0;
    if (in_range) begin
      if (is_word)      rd_val = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
      else if (is_half) rd_val = off[1] ? {16'd0, rd_b[2], rd_b[3]} : {16'd0, rd_b[0], rd_b[1]};
      else              rd_val = {24'd0, rd_b[off[1:0]]};
    end
  end

  // A write cycle leaves the read register (and its PC) untouched
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q <= 32'd0;
      pc_q   <= 32'd0;
    end else if (!write) begin
      data_q <= rd_val;
      pc_q   <= pc_in;
    end
  end

`ifdef MEM_ERR_CHECK_EN
  logic misaligned;
  logic err_q;
  assign misaligned = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) err_q <= 1'b0;
    else        err_q <= !in_range || misaligned;
  end
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  assign data_out = data_q;
  assign pc_out   = pc_q;

  insn_field_decode u_dec (
    .word   (data_q),
    .pc_hi  (pc_q[31:28]),
    .opcode (opcode_out),
    .rs     (rs_out),
    .rt     (rt_out),
    .rd     (rd_out),
    .shamt  (shamt_out),
    .funct  (funct_out),
    .imm    (imm_out),
    .target (target_out),
    .itype  (itype_out)
  );

endmodule

// File: tb/tb_insn_mem_decode.sv
// Self-checking bench for insn_mem_decode: directed vectors plus a randomised scoreboard phase.
module tb_insn_mem_decode;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam logic [31:0] TOP  = 32'h8012_0000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        write = 1'b0;
  logic [1:0]  access_size = 2'b10;
  logic [31:0] pc_in = '0;
  logic [31:0] data_out, pc_out, imm_out, target_out;
  logic [5:0]  opcode_out, funct_out;
  logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
  logic [1:0]  itype_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic        exp_err_q[$];
  logic [31:0] last_rd = '0;
  logic [7:0]  mdl [logic [31:0]];

  insn_mem_decode dut (
    .clk_in(clk_in), .rst_in(rst_in), .address(address), .data_in(data_in),
    .write(write), .access_size(access_size), .pc_in(pc_in),
    .data_out(data_out), .pc_out(pc_out), .opcode_out(opcode_out), .rs_out(rs_out),
    .rt_out(rt_out), .rd_out(rd_out), .shamt_out(shamt_out), .funct_out(funct_out),
    .imm_out(imm_out), .target_out(target_out), .itype_out(itype_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00)      return a;
    else if (sz == 2'b01) return {a[31:1], 1'b0};
    else                  return {a[31:2], 2'b00};
  endfunction

  function automatic logic [7:0] get_b(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] b;
    b = align(a, sz);
    if (!in_rng(b)) return 32'd0;
    if (sz == 2'b00)      return {24'd0, get_b(b)};
    else if (sz == 2'b01) return {16'd0, get_b(b), get_b(b + 1)};
    else                  return {get_b(b), get_b(b + 1), get_b(b + 2), get_b(b + 3)};
  endfunction

  function automatic logic err_exp(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ERR_CHECK_EN
    return !in_rng(a) || (align(a, sz) != a);
`else
    return (a == 32'd0) && (sz == 2'b11) && 1'b0;
`endif
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] b;
    int n;
    address = a; data_in = d; access_size = sz; write = 1'b1;
    @(posedge clk_in); #1;
    write = 1'b0;
    chk("hold", data_out, last_rd);
    b = align(a, sz);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (in_rng(b)) begin
      for (int i = 0; i < n; i++) mdl[b + 32'(i)] = d[8*(n-1-i) +: 8];
    end
  endtask

  task automatic mem_rd(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] pc);
    logic [31:0] e;
    exp_q.push_back(mdl_rd(a, sz));
    exp_pc_q.push_back(pc);
    exp_err_q.push_back(err_exp(a, sz));
    address = a; access_size = sz; pc_in = pc; write = 1'b0;
    @(posedge clk_in); #1;
    e = exp_q.pop_front();
    chk("rd_data", data_out, e);
    chk("rd_pc", pc_out, exp_pc_q.pop_front());
    chk("rd_err", {31'd0, err_out}, {31'd0, exp_err_q.pop_front()});
    last_rd = e;
  endtask

  initial begin
    #1 rst_in = 1'b1;
    #2;
    chk("rst_data", data_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    chk("rst_itype", {30'd0, itype_out}, 32'd0);
    chk("rst_opcode", {26'd0, opcode_out}, 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;

    // I-type load
    mem_wr(BASE, 32'h8C22_0010, 2'b10);
    mem_rd(BASE, 2'b10, 32'h8002_0000);
    chk("i_opcode", {26'd0, opcode_out}, 32'h23);
    chk("i_rs", {27'd0, rs_out}, 32'd1);
    chk("i_rt", {27'd0, rt_out}, 32'd2);
    chk("i_imm", imm_out, 32'h10);
    chk("i_itype", {30'd0, itype_out}, 32'd2);

    // Byte writes assembled big-endian
    mem_wr(BASE + 4, 32'h0000_0011, 2'b00);
    mem_wr(BASE + 5, 32'hFFFF_FF22, 2'b00);
    mem_wr(BASE + 6, 32'h0000_0033, 2'b00);
    mem_wr(BASE + 7, 32'h0000_0044, 2'b00);
    mem_rd(BASE + 4, 2'b10, 32'h0);
    chk("bw_word", data_out, 32'h1122_3344);
    mem_rd(BASE + 6, 2'b01, 32'h0);
    chk("bw_half", data_out, 32'h0000_3344);
    mem_rd(BASE + 5, 2'b00, 32'h4);
    mem_rd(BASE + 7, 2'b01, 32'h8);
    mem_rd(BASE + 6, 2'b11, 32'hC);

    // R-type
    mem_wr(BASE + 8, 32'h0043_2020, 2'b10);
    mem_rd(BASE + 8, 2'b10, 32'h8002_0008);
    chk("r_rs", {27'd0, rs_out}, 32'd2);
    chk("r_rt", {27'd0, rt_out}, 32'd3);
    chk("r_rd", {27'd0, rd_out}, 32'd4);
    chk("r_shamt", {27'd0, shamt_out}, 32'd0);
    chk("r_funct", {26'd0, funct_out}, 32'h20);
    chk("r_itype", {30'd0, itype_out}, 32'd0);

    // J-type
    mem_wr(BASE + 12, 32'h0800_0040, 2'b10);
    mem_rd(BASE + 12, 2'b10, 32'h8002_000C);
    chk("j_target", target_out, 32'h8000_0100);
    chk("j_itype", {30'd0, itype_out}, 32'd1);

    // Negative immediate, then halfword overwrite of its low half
    mem_wr(BASE + 16, 32'h2401_FFF0, 2'b10);
    mem_rd(BASE + 16, 2'b10, 32'h8002_0010);
    chk("neg_imm", imm_out, 32'hFFFF_FFF0);
    mem_wr(BASE + 18, 32'h1234_ABCD, 2'b01);
    mem_rd(BASE + 16, 2'b10, 32'h0);
    chk("half_wr", data_out, 32'h2401_ABCD);
    mem_rd(BASE + 19, 2'b10, 32'h0);

    // Range boundaries
    mem_rd(32'h0000_1000, 2'b10, 32'h0);
    chk("oor_data", data_out, 32'd0);
    mem_rd(BASE - 4, 2'b10, 32'h0);
    mem_wr(TOP, 32'hDEAD_BEEF, 2'b10);
    mem_rd(BASE, 2'b10, 32'h0);
    mem_wr(TOP - 4, 32'hCAFE_F00D, 2'b10);
    mem_rd(TOP - 4, 2'b10, 32'h0);
    mem_rd(TOP, 2'b10, 32'h0);

    // Asynchronous reset in the middle of a cycle
    mem_rd(BASE + 4, 2'b10, 32'h8002_0004);
    #2 rst_in = 1'b1;
    #1;
    chk("async_data", data_out, 32'd0);
    chk("async_pc", pc_out, 32'd0);
    chk("async_err", {31'd0, err_out}, 32'd0);
    chk("async_itype", {30'd0, itype_out}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    last_rd = 32'd0;
    mem_rd(BASE, 2'b10, 32'h8002_0000);
    chk("post_rst", data_out, 32'h8C22_0010);

    // Randomised traffic around the bottom window and the top edge
    for (int i = 0; i < 16; i++) mem_wr(BASE + 32'h100 + 32'(4 * i), 32'd0, 2'b10);
    for (int i = 0; i < 8; i++)  mem_wr(TOP - 32'h20 + 32'(4 * i), 32'd0, 2'b10);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      if ($urandom_range(0, 7) == 0) a = TOP - 32'h20 + 32'($urandom_range(0, 63));
      else                           a = BASE + 32'h100 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) mem_wr(a, $urandom, sz);
      else                           mem_rd(a, sz, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
